// File: rtl/rl_router_port_sync_if.sv
// Handshake bundle for rl_router_port_sync: routed core input, network and local
// outputs, arbiter-to-core injection path and the drop counter.
interface rl_router_port_sync_if #(
  parameter int WIDTH   = 11,
  parameter int NUM_OUT = 3
);
  logic                       in_valid;
  logic                       in_ready;
  logic [WIDTH-1:0]           in_data;
  logic [NUM_OUT-1:0]         out_valid;
  logic [NUM_OUT-1:0]         out_ready;
  logic [NUM_OUT*WIDTH-1:0]   out_data;
  logic                       local_valid;
  logic                       local_ready;
  logic [WIDTH-1:0]           local_data;
  logic                       inj_valid;
  logic                       inj_ready;
  logic [WIDTH-1:0]           inj_data;
  logic                       core_valid;
  logic                       core_ready;
  logic [WIDTH-1:0]           core_data;
  logic [7:0]                 drop_count;

  modport slave (
    input  in_valid, in_data, out_ready, local_ready, inj_valid, inj_data, core_ready,
    output in_ready, out_valid, out_data, local_valid, local_data, inj_ready,
           core_valid, core_data, drop_count
  );

  modport master (
    output in_valid, in_data, out_ready, local_ready, inj_valid, inj_data, core_ready,
    input  in_ready, out_valid, out_data, local_valid, local_data, inj_ready,
           core_valid, core_data, drop_count
  );
endinterface

// File: rtl/rl_router_port_sync.sv
// Clocked RL router stage: routes core flits by relative destination into per-channel
// FIFOs (network channels + local eject), drops unmapped routes, buffers injection.
module rl_router_port_sync #(
  parameter int WIDTH     = 11,
  parameter int ADDR_BITS = 3,
  parameter int NUM_OUT   = 3,
  parameter int DEPTH     = 4,
  parameter int ROUTER_ID = 0,
  parameter int CH_BITS   = $clog2(NUM_OUT + 1),
  parameter logic [(2**ADDR_BITS)*CH_BITS-1:0] ROUTE_MAP = 16'h9463
) (
  input  logic                  clk,
  input  logic                  rst_n,
  rl_router_port_sync_if.slave  bus
);

  // Channel index space: 0..NUM_OUT-1 network, NUM_OUT local eject, NUM_OUT+1 injection.
  localparam int NCH      = NUM_OUT + 2;
  localparam int LOC      = NUM_OUT;
  localparam int INJ      = NUM_OUT + 1;
  localparam int PTR_BITS = $clog2(DEPTH);
  localparam int CNT_BITS = $clog2(DEPTH + 1);
  localparam logic [ADDR_BITS-1:0] RID       = ADDR_BITS'(ROUTER_ID);
  localparam logic [CH_BITS-1:0]   LOCAL_SEL = CH_BITS'(NUM_OUT);

  logic [NCH-1:0]           push;
  logic [NCH-1:0]           pop;
  logic [NCH-1:0]           full;
  logic [NCH-1:0]           empty;
  logic [WIDTH-1:0]         wdata [NCH];
  logic [WIDTH-1:0]         rdata [NCH];

  logic [ADDR_BITS-1:0]     diff;
  logic [CH_BITS-1:0]       sel;
  logic                     drop;
  logic                     tgt_full;
  logic                     in_ready;
  logic                     inj_ready;
  logic                     accept;
  logic [NUM_OUT-1:0]       net_valid;
  logic [NUM_OUT*WIDTH-1:0] net_data;
  logic [7:0]               drop_cnt_q;
  logic [7:0]               drop_cnt_d;

  assign diff = bus.in_data[ADDR_BITS:1] - RID;
  assign sel  = ROUTE_MAP[diff*CH_BITS +: CH_BITS];
  assign drop = (sel > LOCAL_SEL);

  always_comb begin
    tgt_full = 1'b0;
    for (int i = 0; i <= NUM_OUT; i++) begin
      if (sel == CH_BITS'(i)) tgt_full = full[i];
    end
  end

  // Readiness looks only at the pre-edge occupancy, never at this cycle's pop.
  assign in_ready  = rst_n & (drop | ~tgt_full);
  assign inj_ready = rst_n & ~full[INJ];
  assign accept    = bus.in_valid & in_ready;

  genvar gi;
  generate
    for (gi = 0; gi <= NUM_OUT; gi++) begin : g_route
      assign push[gi]  = accept & ~drop & (sel == CH_BITS'(gi));
      assign wdata[gi] = bus.in_data;
    end

    for (gi = 0; gi < NUM_OUT; gi++) begin : g_net
      assign pop[gi]                     = ~empty[gi] & bus.out_ready[gi];
      assign net_valid[gi]               = ~empty[gi];
      assign net_data[gi*WIDTH +: WIDTH] = rdata[gi];
    end

    for (gi = 0; gi < NCH; gi++) begin : g_fifo
      logic [WIDTH-1:0]    mem [DEPTH];
      logic [PTR_BITS-1:0] wr_q;
      logic [PTR_BITS-1:0] rd_q;
      logic [CNT_BITS-1:0] cnt_q;
      logic [CNT_BITS-1:0] cnt_d;
      logic [WIDTH-1:0]    last_q;

      always_comb begin
        cnt_d = cnt_q;
        if (push[gi] && !pop[gi]) cnt_d = cnt_q + 1'b1;
        else if (!push[gi] && pop[gi]) cnt_d = cnt_q - 1'b1;
      end

      always_ff @(posedge clk) begin
        if (push[gi]) mem[wr_q] <= wdata[gi];
      end

      // last_q keeps the most recently popped flit so an idle port never shows stale RAM.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          wr_q   <= '0;
          rd_q   <= '0;
          cnt_q  <= '0;
          last_q <= '0;
        end else begin
          cnt_q <= cnt_d;
          if (push[gi]) wr_q <= wr_q + 1'b1;
          if (pop[gi]) begin
            rd_q   <= rd_q + 1'b1;
            last_q <= mem[rd_q];
          end
        end
      end

      assign full[gi]  = (cnt_q == CNT_BITS'(DEPTH));
      assign empty[gi] = (cnt_q == '0);
      assign rdata[gi] = empty[gi] ? last_q : mem[rd_q];
    end
  endgenerate

  assign push[INJ]  = bus.inj_valid & inj_ready;
  assign wdata[INJ] = bus.inj_data;
  assign pop[LOC]   = ~empty[LOC] & bus.local_ready;
  assign pop[INJ]   = ~empty[INJ] & bus.core_ready;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (accept && drop && (drop_cnt_q != 8'hFF)) drop_cnt_d = drop_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_cnt_q <= '0;
    else        drop_cnt_q <= drop_cnt_d;
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = net_valid;
  assign bus.out_data    = net_data;
  assign bus.local_valid = ~empty[LOC];
  assign bus.local_data  = rdata[LOC];
  assign bus.inj_ready   = inj_ready;
  assign bus.core_valid  = ~empty[INJ];
  assign bus.core_data   = rdata[INJ];
  assign bus.drop_count  = drop_cnt_q;

endmodule

// File: tb/tb_rl_router_port_sync.sv
// Scoreboard bench for rl_router_port_sync: directed and random traffic on a default
// instance, plus a relative-address instance (ROUTER_ID=2) and a drop-map instance.
module tb_rl_router_port_sync;
  localparam int W     = 11;
  localparam int DEPTH = 4;
  localparam int RID_A = 0;
  // Relative destination -> channel for the default map (3 = local eject).
  localparam int MAP_A [8] = '{3, 0, 2, 1, 0, 1, 1, 2};

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  rl_router_port_sync_if #(.WIDTH(W), .NUM_OUT(3)) ifa ();
  rl_router_port_sync_if #(.WIDTH(W), .NUM_OUT(3)) ifb ();
  rl_router_port_sync_if #(.WIDTH(W), .NUM_OUT(2)) ifc ();

  rl_router_port_sync dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  rl_router_port_sync #(.ROUTER_ID(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
  rl_router_port_sync #(.NUM_OUT(2), .ROUTE_MAP(16'h94E3)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

  // Scoreboard state for dut_a: expected flits per channel and injection path.
  logic [W-1:0] exp_q [4][$];
  logic [W-1:0] inj_q [$];
  int           occ [4];
  int           iocc;
  logic [W-1:0] last_pop [4];
  logic [W-1:0] last_core;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int route_a(input logic [W-1:0] f);
    int d;
    d = (int'(f[3:1]) - RID_A + 8) % 8;
    return MAP_A[d];
  endfunction

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: handshake never completed, got in_ready 0 expected 1 at %0t", name, $time);
  endtask

  task automatic send_a(input logic [W-1:0] f);
    bit done = 0;
    int w = 0;
    ifa.in_valid = 1'b1;
    ifa.in_data  = f;
    while (!done && w < 300) begin
      @(negedge clk);
      if (ifa.in_ready) begin
        exp_q[route_a(f)].push_back(f);
        done = 1;
      end
      w++;
    end
    if (!done) timeout_fail("send_timeout");
    @(posedge clk); #1;
    ifa.in_valid = 1'b0;
  endtask

  task automatic send_inj(input logic [W-1:0] f);
    bit done = 0;
    int w = 0;
    ifa.inj_valid = 1'b1;
    ifa.inj_data  = f;
    while (!done && w < 300) begin
      @(negedge clk);
      if (ifa.inj_ready) begin
        inj_q.push_back(f);
        done = 1;
      end
      w++;
    end
    if (!done) timeout_fail("inj_timeout");
    @(posedge clk); #1;
    ifa.inj_valid = 1'b0;
  endtask

  // Monitor: sampled on the falling edge, when all handshake signals are settled.
  logic         m_v, m_r, m_rdy_exp, m_irdy_exp;
  logic [W-1:0] m_d;
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < 4; c++) begin
        exp_q[c].delete();
        occ[c]      = 0;
        last_pop[c] = '0;
      end
      inj_q.delete();
      iocc      = 0;
      last_core = '0;
    end else begin
      m_rdy_exp  = (occ[route_a(ifa.in_data)] < DEPTH);
      m_irdy_exp = (iocc < DEPTH);
      chk("in_ready", ifa.in_ready, m_rdy_exp);
      chk("inj_ready", ifa.inj_ready, m_irdy_exp);
      for (int c = 0; c < 4; c++) begin
        m_v = (c < 3) ? ifa.out_valid[c] : ifa.local_valid;
        m_r = (c < 3) ? ifa.out_ready[c] : ifa.local_ready;
        m_d = (c < 3) ? ifa.out_data[c*W +: W] : ifa.local_data;
        chk($sformatf("valid_ch%0d", c), m_v, occ[c] != 0);
        if (!m_v) chk($sformatf("idle_data_ch%0d", c), m_d, last_pop[c]);
        else if (exp_q[c].size() == 0) chk($sformatf("queue_ch%0d", c), exp_q[c].size(), 1);
        else begin
          chk($sformatf("head_ch%0d", c), m_d, exp_q[c][0]);
          if (m_r) begin
            last_pop[c] = exp_q[c].pop_front();
            occ[c]--;
            $display("ch%0d pop %03h", c, m_d);
          end
        end
      end
      if (!ifa.core_valid) chk("core_idle_data", ifa.core_data, last_core);
      chk("core_valid", ifa.core_valid, iocc != 0);
      if (ifa.core_valid && inj_q.size() != 0) begin
        chk("core_head", ifa.core_data, inj_q[0]);
        if (ifa.core_ready) begin
          last_core = inj_q.pop_front();
          iocc--;
          $display("core pop %03h", ifa.core_data);
        end
      end
      if (ifa.in_valid && ifa.in_ready) occ[route_a(ifa.in_data)]++;
      if (ifa.inj_valid && ifa.inj_ready) iocc++;
    end
  end

  bit r_done, i_done, inj_dir_done;
  logic [W-1:0] fb1, fb2, fr;

  initial begin
    ifa.in_valid = 0; ifa.in_data = '0; ifa.out_ready = '1; ifa.local_ready = 1;
    ifa.inj_valid = 0; ifa.inj_data = '0; ifa.core_ready = 1;
    ifb.in_valid = 0; ifb.in_data = '0; ifb.out_ready = '1; ifb.local_ready = 1;
    ifb.inj_valid = 0; ifb.inj_data = '0; ifb.core_ready = 1;
    ifc.in_valid = 0; ifc.in_data = '0; ifc.out_ready = '1; ifc.local_ready = 1;
    ifc.inj_valid = 0; ifc.inj_data = '0; ifc.core_ready = 1;

    #1 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", ifa.in_ready, 0);
    chk("rst_inj_ready", ifa.inj_ready, 0);
    chk("rst_out_valid", ifa.out_valid, 0);
    chk("rst_out_data", ifa.out_data, 0);
    chk("rst_local", {ifa.local_valid, ifa.local_data}, 0);
    chk("rst_core", {ifa.core_valid, ifa.core_data}, 0);
    chk("rst_drop", ifa.drop_count, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Default routing, all readies high.
    send_a({7'h15, 3'd1, 1'b0});
    send_a({7'h15, 3'd5, 1'b0});
    send_a({7'h15, 3'd7, 1'b0});
    send_a({7'h15, 3'd0, 1'b0});
    repeat (3) @(posedge clk);
    #1;

    // ROUTER_ID=2: dest 1 wraps to diff 7 (ch2), dest 6 is diff 4 (ch0).
    fb1 = {7'h33, 3'd1, 1'b1};
    fb2 = {7'h4C, 3'd6, 1'b0};
    ifb.in_valid = 1; ifb.in_data = fb1;
    @(negedge clk); chk("b_ready1", ifb.in_ready, 1);
    @(posedge clk); #1 ifb.in_data = fb2;
    @(negedge clk);
    chk("b_ready2", ifb.in_ready, 1);
    chk("b_valid_ch2", ifb.out_valid, 3'b100);
    chk("b_data_ch2", ifb.out_data[2*W +: W], fb1);
    @(posedge clk); #1 ifb.in_valid = 0;
    @(negedge clk);
    chk("b_valid_ch0", ifb.out_valid, 3'b001);
    chk("b_data_ch0", ifb.out_data[0 +: W], fb2);
    @(negedge clk);
    chk("b_idle_valid", {ifb.out_valid, ifb.local_valid}, 0);
    chk("b_held_ch2", ifb.out_data[2*W +: W], fb1);
    @(posedge clk); #1;

    // Backpressure on channel 0: four fill the FIFO, the fifth waits for a pop.
    ifa.out_ready[0] = 1'b0;
    for (int k = 0; k < 4; k++) send_a({7'(k + 1), 3'd1, 1'b0});
    fork
      send_a({7'h05, 3'd1, 1'b0});
      begin repeat (3) @(posedge clk); #1 ifa.out_ready[0] = 1'b1; end
    join
    repeat (8) @(posedge clk);
    #1;

    // Injection with toggling core_ready, concurrent with channel 1 traffic.
    inj_dir_done = 0;
    fork
      begin for (int k = 1; k <= 6; k++) send_inj(W'(k)); inj_dir_done = 1; end
      begin for (int k = 1; k <= 6; k++) send_a({7'(k + 8'h40), 3'd5, 1'b1}); end
      begin
        for (int n = 0; n < 300 && !inj_dir_done; n++) begin
          @(posedge clk); #1 ifa.core_ready = ~ifa.core_ready;
        end
      end
    join
    ifa.core_ready = 1;

    // Random traffic on both paths with random readies.
    r_done = 0; i_done = 0;
    fork
      begin
        for (int k = 0; k < 200; k++) begin
          int gap = $urandom_range(0, 2);
          if (gap > 0) begin repeat (gap) @(posedge clk); #1; end
          fr = W'($urandom);
          send_a(fr);
        end
        r_done = 1;
      end
      begin
        for (int k = 0; k < 100; k++) begin
          int gap = $urandom_range(0, 3);
          if (gap > 0) begin repeat (gap) @(posedge clk); #1; end
          send_inj(W'($urandom));
        end
        i_done = 1;
      end
      begin
        for (int n = 0; n < 20000 && !(r_done && i_done); n++) begin
          @(posedge clk); #1;
          ifa.out_ready   = 3'($urandom);
          ifa.local_ready = 1'($urandom);
          ifa.core_ready  = 1'($urandom);
        end
      end
    join
    ifa.out_ready = '1; ifa.local_ready = 1; ifa.core_ready = 1;
    repeat (10) @(posedge clk);
    #1;
    for (int c = 0; c < 4; c++) chk($sformatf("drain_ch%0d", c), exp_q[c].size(), 0);
    chk("drain_inj", inj_q.size(), 0);

    // Drop path: 300 unmapped flits, counter saturates at 255.
    ifc.in_valid = 1; ifc.in_data = {7'h2A, 3'd3, 1'b1};
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      chk("c_in_ready", ifc.in_ready, 1);
      chk("c_no_valid", {ifc.out_valid, ifc.local_valid}, 0);
      if (i == 100 || i == 255 || i == 299)
        chk("c_drop_count", ifc.drop_count, (i < 255) ? i : 255);
      @(posedge clk); #1 ifc.in_data[W-1:4] = 7'($urandom);
    end
    ifc.in_valid = 0;
    @(negedge clk); chk("c_drop_final", ifc.drop_count, 255);
    @(posedge clk); #1;

    // Reset mid-operation with channels 0 and 2 holding three flits each.
    ifa.out_ready = 3'b010;
    for (int k = 0; k < 3; k++) send_a({7'(k + 8'h60), 3'd1, 1'b0});
    for (int k = 0; k < 3; k++) send_a({7'(k + 8'h70), 3'd7, 1'b0});
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", ifa.out_valid, 0);
    chk("mid_rst_out_data", ifa.out_data, 0);
    chk("mid_rst_other_valid", {ifa.local_valid, ifa.core_valid}, 0);
    chk("mid_rst_in_ready", ifa.in_ready, 0);
    chk("mid_rst_drop_a", ifa.drop_count, 0);
    chk("mid_rst_drop_c", ifc.drop_count, 0);
    @(posedge clk); @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    fr = {7'h55, 3'd1, 1'b1};
    send_a(fr);
    @(negedge clk);
    chk("post_rst_valid", ifa.out_valid, 3'b001);
    chk("post_rst_data", ifa.out_data[0 +: W], fr);
    @(posedge clk); #1 ifa.out_ready = '1;
    repeat (3) @(posedge clk);
    #1;
    for (int c = 0; c < 4; c++) chk($sformatf("final_ch%0d", c), exp_q[c].size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end
endmodule
